ram: RTL and testbench
======================

# ram

Word-organised 256-byte memory acting as an Avalon memory-mapped slave for the `top_level_cpu` bus master, with a side-band preload port used by benches to write program words before execution. It holds both instructions and data for the CPU, and the CPU's `address` bus is connected directly to it. Byte-lane write enables follow Avalon conventions, and an optional wait-state generator exercises the master's `waitrequest` handling.

## Interface
- Parameters: none. Geometry is fixed by the shared package constants.
- `clk`  in  1  single system clock; rising edge active.
- `RAM_Reset`  in  1  reset, synchronous and active-high.
- `address`  in  32  Avalon byte address; only bits [7:2] are decoded.
- `read`  in  1  Avalon read request.
- `write`  in  1  Avalon write request.
- `writedata`  in  32  Avalon write data.
- `byteenable`  in  4  lane enables; bit n covers data bits [8n+7:8n].
- `readdata`  out  32  Avalon read data.
- `waitrequest`  out  1  Avalon stall.
- `inst_input`  in  1  preload enable.
- `inst_addr`  in  8  preload byte address; bits [7:2] select the word.
- `instruction`  in  32  preload data word.

## Operation
- Storage is 64 × 32-bit words, little-endian.
- Word index is `address[7:2]`. Bits [31:8] and [1:0] are ignored, so 0xBFC00004 aliases word 1.
- **Preload**
  - Level-sensitive and independent of `clk`.
  - While `inst_input` is 1, `mem[inst_addr[7:2]]` follows `instruction` continuously. The final value is whatever is present when `inst_input` falls or the address changes.
  - Preload works in either clock phase and during reset.
  - Preload has priority over reset clear and over Avalon writes to the same word.
- **Avalon write**
  - On a rising `clk` edge with `write`=1, `waitrequest`=0 and `RAM_Reset`=0, each lane n with `byteenable[n]`=1 takes `writedata[8n+7:8n]`.
  - Lanes that are not enabled are unchanged.
- **Avalon read**
  - `readdata` = `mem[address[7:2]]`, combinational, whenever `read`=1 and `waitrequest`=0.
  - Otherwise `readdata` = 0.
  - `byteenable` is ignored on reads; the full word is always returned.
- **Read and write asserted together:** the write is performed and `readdata` shows the pre-write contents during that cycle.
- **Reset:** a rising edge with `RAM_Reset`=1 clears every word to 0, except words being preloaded. Avalon writes in that cycle are dropped.
- **Wait states:** with wait states compiled out, `waitrequest` is constant 0.

## Timing
- Reset values: all words 0; `readdata` 0; `waitrequest` 0; wait FSM in IDLE.
- Without wait states:
  - read latency is 0 cycles, with data valid in the same cycle as `read`;
  - a write commits at the first rising edge.
- Wait FSM states: IDLE and WAIT.
  - IDLE → WAIT when `read` or `write` is high and `RAM_Reset` is 0. `waitrequest` is 1 combinationally in IDLE while a request is present.
  - WAIT: `waitrequest` = 0, the access completes, then the FSM returns to IDLE.
  - A request dropped while in WAIT returns the FSM to IDLE with no access performed.
  - Back-to-back requests alternate between stall and completion: 2 cycles per access.
- Reset asserted mid-access forces IDLE on the next edge and drops the pending write.
- Master rule: `address`, `read`, `write`, `writedata` and `byteenable` must be held stable while `waitrequest` = 1.

## Configuration
- `RAM_WAITSTATE_EN`
  - Defined: the wait FSM is compiled in and every access costs exactly one stall cycle.
  - Undefined: the FSM is removed, `waitrequest` is tied to 0, and all other behaviour is identical.

## Structure
- Package `ram_pkg`:
  - `RAM_WORDS`=64, `IDX_MSB`=7, `IDX_LSB`=2;
  - `word_t` (logic[31:0]);
  - `wait_state_t` enum {IDLE, WAIT}.
- Sub-module `ram_wait_ctrl`:
  - holds the wait FSM and produces `waitrequest` and an internal `access_ok` strobe;
  - instantiated only under `RAM_WAITSTATE_EN`.
- The storage array and lane-write logic stay in `ram`.

## Test plan
- **Reset:** hold `RAM_Reset` for 1 edge, then read 0x04 → `readdata` = 0x00000000 and `waitrequest` = 0.
- **Preload:**
  - pulse `inst_input` between clock edges with `inst_addr`=0x0C, `instruction`=0x18600002;
  - read 0x0C → 0x18600002;
  - read 0xBFC0000C → 0x18600002 (aliasing).
- **Byte write:** after reset, write 0x10 with `writedata`=0xAABBCCDD and `byteenable`=4'b0101, then read 0x10 → 0x00BB00DD.
- **Reset mid-write:** assert `write` to 0x14 together with `RAM_Reset` → a later read of 0x14 returns 0.
- **Wait states** (`RAM_WAITSTATE_EN` defined): read 0x04 holding 0x24020010 → `waitrequest`=1 in cycle 1; `waitrequest`=0 and `readdata`=0x24020010 in cycle 2.
- **System (with `top_level_cpu`):**
  - preload 0x04..0x1C = 24020010, 00000000, 18600002, 24420020, 24420030, 24420040, 00000008;
  - release reset → at the falling edge of `active`, `register_v0` = 0x70 within 1000 cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared geometry, types and helpers for the ram slave.
// Optional wait-state generator is selected with RAM_WAITSTATE_EN.
package ram_pkg;

    localparam int unsigned RAM_WORDS = 64;
    localparam int unsigned IDX_MSB   = 7;
    localparam int unsigned IDX_LSB   = 2;
    localparam int unsigned IDX_W     = IDX_MSB - IDX_LSB + 1;

    typedef logic [31:0]      word_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE,
        WAIT
    } wait_state_t;

    // Replace only the byte lanes selected by be; other lanes keep cur.
    function automatic word_t lane_merge(word_t cur, word_t wdata, logic [3:0] be);
        word_t res;
        res = cur;
        for (int unsigned n = 0; n < 4; n++) begin
            if (be[n]) res[8*n +: 8] = wdata[8*n +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_wait_ctrl.sv
// One-stall-per-access wait-state generator for the ram Avalon slave.
// Only present when RAM_WAITSTATE_EN is defined; otherwise ram ties
// waitrequest low and this file contributes no module.
`ifdef RAM_WAITSTATE_EN
module ram_wait_ctrl
    import ram_pkg::*;
(
    input  logic clk,
    input  logic i_rst,
    input  logic i_req,
    output logic o_waitrequest,
    output logic o_access_ok
);

    wait_state_t r_state;

    // IDLE stalls a fresh request for one cycle; WAIT lets it complete.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_req) r_state <= WAIT;
                WAIT:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_waitrequest = (r_state == IDLE) && i_req;
    assign o_access_ok   = (r_state == WAIT);

endmodule
`endif

// File: rtl/ram.sv
// 64 x 32-bit Avalon-MM slave memory with byte-lane writes and a
// level-sensitive preload port. Define RAM_WAITSTATE_EN to add one stall
// cycle per access via ram_wait_ctrl.
module ram
    import ram_pkg::*;
(
    input  logic        clk,
    input  logic        RAM_Reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);

    word_t r_mem [RAM_WORDS];

    // Preload slot: a transparent latch tracks the port while inst_input is
    // high, and r_pl_vld keeps it pending until the next clock edge folds it
    // into r_mem. Reads see the slot directly, so preload takes effect at once
    // and survives reset and colliding Avalon writes.
    idx_t  r_pl_idx;
    word_t r_pl_val;
    logic  r_pl_vld;

    logic  w_waitrequest;
    logic  w_access_ok;
    idx_t  w_idx;
    logic  w_pl_hit;
    word_t w_word;
    logic  w_unused;

    assign w_idx    = address[IDX_MSB:IDX_LSB];
    assign w_unused = ^{address[31:8], address[1:0], inst_addr[1:0]};

`ifdef RAM_WAITSTATE_EN
    ram_wait_ctrl u_wait_ctrl (
        .clk           (clk),
        .i_rst         (RAM_Reset),
        .i_req         (read | write),
        .o_waitrequest (w_waitrequest),
        .o_access_ok   (w_access_ok)
    );
`else
    assign w_waitrequest = 1'b0;
    assign w_access_ok   = 1'b1;
`endif

    assign waitrequest = w_waitrequest;

    // Capture preload address/data while the preload enable is high.
    always_latch begin
        if (inst_input) begin
            r_pl_idx <= inst_addr[IDX_MSB:IDX_LSB];
            r_pl_val <= instruction;
        end
    end

    // Pending flag: set as soon as preload starts, cleared at the first clock
    // edge after it ends (that edge commits the slot).
    always_ff @(posedge clk or posedge inst_input) begin
        if (inst_input) r_pl_vld <= 1'b1;
        else            r_pl_vld <= 1'b0;
    end

    // Storage update: reset clear or lane write, then preload overrides.
    always_ff @(posedge clk) begin
        if (RAM_Reset) begin
            for (int unsigned i = 0; i < RAM_WORDS; i++) r_mem[i] <= '0;
        end else if (write && w_access_ok) begin
            r_mem[w_idx] <= lane_merge(r_mem[w_idx], writedata, byteenable);
        end
        if (r_pl_vld || inst_input) r_mem[r_pl_idx] <= r_pl_val;
    end

    // Combinational read path with preload slot forwarding.
    always_comb begin
        w_pl_hit = (r_pl_vld || inst_input) && (r_pl_idx == w_idx);
        w_word   = w_pl_hit ? r_pl_val : r_mem[w_idx];
        readdata = (read && !w_waitrequest) ? w_word : '0;
    end

endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: read requests push the expected word, a monitor
// pops and compares whenever the slave presents read data.
module tb_ram;

    logic        clk = 1'b0;
    logic        RAM_Reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic [31:0] instruction;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [31:0] exp_q  [$];
    string       name_q [$];

    ram dut (
        .clk         (clk),
        .RAM_Reset   (RAM_Reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .inst_input  (inst_input),
        .inst_addr   (inst_addr),
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
        end
    endtask

    // Monitor: every completed read is matched against the scoreboard.
    initial begin
        logic [31:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (read && !waitrequest) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read actual=%08h expected=none", readdata);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    chk(n, readdata, e);
                end
            end
        end
    end

    // Hold the current request until the slave stops stalling.
    task automatic wait_accept(input string nm, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=stalled expected=accepted", nm);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] exp, input string nm);
        logic ok;
        @(posedge clk); #1;
        address = a; byteenable = be; read = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        wait_accept(nm, ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input string nm);
        logic ok;
        @(posedge clk); #1;
        address = a; writedata = d; byteenable = be; write = 1'b1;
        wait_accept(nm, ok);
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        RAM_Reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0; inst_input = 1'b0;
        inst_addr = '0; instruction = '0;
        @(posedge clk); #1;
        RAM_Reset = 1'b0;

        // Reset state
        #2;
        chk("reset_waitrequest", {31'b0, waitrequest}, 32'h0);
        chk("idle_readdata", readdata, 32'h0);
        do_read(32'h04, 4'hF, 32'h0000_0000, "reset_word1");

        // Preload pulse between clock edges; last value before fall wins
        @(posedge clk); #2;
        inst_addr = 8'h0C; instruction = 32'hFFFF_FFFF; inst_input = 1'b1;
        #1 instruction = 32'h1860_0002;
        #1 inst_input = 1'b0;
        do_read(32'h0C, 4'hF, 32'h1860_0002, "preload_0c");
        do_read(32'hBFC0_000C, 4'hF, 32'h1860_0002, "preload_alias");

        // Byte-lane writes
        do_write(32'h10, 32'hAABB_CCDD, 4'b0101, "bytewr_a");
        do_read(32'h10, 4'hF, 32'h00BB_00DD, "bytewr_0101");
        do_write(32'h10, 32'h1122_3344, 4'b1010, "bytewr_b");
        do_read(32'h10, 4'b0001, 32'h11BB_33DD, "bytewr_1010_fullread");
        do_write(32'hFFFF_FF2B, 32'hDEAD_BEEF, 4'hF, "alias_wr");
        do_read(32'h28, 4'hF, 32'hDEAD_BEEF, "alias_wr_rd");

        // Read and write together: old word visible, new word committed
        do_write(32'h24, 32'h0102_0304, 4'hF, "rw_init");
        @(posedge clk); #1;
        address = 32'h24; writedata = 32'h0A0B_0C0D; byteenable = 4'hF;
        read = 1'b1; write = 1'b1;
        exp_q.push_back(32'h0102_0304);
        name_q.push_back("rw_same_cycle_old");
        wait_accept("rw_same_cycle", ok);
        if (!ok) begin
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        @(posedge clk); #1;
        read = 1'b0; write = 1'b0;
        do_read(32'h24, 4'hF, 32'h0A0B_0C0D, "rw_committed");

        // Preload beats a colliding Avalon write
        @(posedge clk); #1;
        inst_addr = 8'h1C; instruction = 32'h1234_5678; inst_input = 1'b1;
        do_write(32'h1C, 32'hFFFF_FFFF, 4'hF, "pl_vs_wr");
        inst_input = 1'b0;
        do_read(32'h1C, 4'hF, 32'h1234_5678, "preload_priority");

        // Reset mid-write with a preload held across the reset edge
        @(posedge clk); #1;
        address = 32'h14; writedata = 32'h5555_5555; byteenable = 4'hF;
        write = 1'b1; RAM_Reset = 1'b1;
        inst_addr = 8'h18; instruction = 32'hCAFE_F00D; inst_input = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; RAM_Reset = 1'b0; inst_input = 1'b0;
        do_read(32'h14, 4'hF, 32'h0000_0000, "reset_drops_write");
        do_read(32'h10, 4'hF, 32'h0000_0000, "reset_clears");
        do_read(32'h18, 4'hF, 32'hCAFE_F00D, "preload_survives_reset");

        // No read request: output held at zero
        @(posedge clk); #1;
        address = 32'h18; read = 1'b0;
        #1 chk("no_read_zero", readdata, 32'h0);

`ifdef RAM_WAITSTATE_EN
        // One stall cycle, then data
        @(posedge clk); #2;
        inst_addr = 8'h04; instruction = 32'h2402_0010; inst_input = 1'b1;
        #1 inst_input = 1'b0;
        @(posedge clk); #1;
        address = 32'h04; read = 1'b1;
        exp_q.push_back(32'h2402_0010);
        name_q.push_back("ws_cycle2_data");
        @(negedge clk);
        chk("ws_cycle1_wait", {31'b0, waitrequest}, 32'h1);
        @(negedge clk);
        chk("ws_cycle2_wait", {31'b0, waitrequest}, 32'h0);
        @(posedge clk); #1;
        read = 1'b0;
`endif

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
